// File: rtl/sigmag_pkg.sv
// Shared types for the sign/magnitude statistic scan controller: FSM states,
// default counter width and the captured-result payload.
package sigmag_pkg;

  localparam int unsigned CNTR_LENGTH_DEF = 16;
  localparam int unsigned NCH_DEF         = 4;
  localparam int unsigned RES_CH_MAX      = 8;
  localparam int unsigned RES_CNT_MAX     = 32;

  typedef enum logic [3:0] {
    IDLE,
    SELECT,
    SETTLE,
    CLEAR,
    ARM,
    WAIT,
    PRESENT,
    NEXT,
    FINISH
  } state_e;

  // Sized for the widest supported build; narrower builds use the low bits.
  typedef struct packed {
    logic [RES_CH_MAX-1:0]  ch;
    logic [RES_CNT_MAX-1:0] sig;
    logic [RES_CNT_MAX-1:0] mag;
    logic                   err;
  } res_t;

endpackage

// File: rtl/sigmag_scan_ctrl_if.sv
// Result handshake bus between the scan controller (master) and its consumer.
interface sigmag_scan_ctrl_if #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CNTR_LENGTH = 16
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                   res_valid;
  logic                   res_ready;
  logic [CHW-1:0]         res_ch;
  logic [CNTR_LENGTH-1:0] res_sig;
  logic [CNTR_LENGTH-1:0] res_mag;
  logic                   res_err;

  modport master (output res_valid, res_ch, res_sig, res_mag, res_err, input res_ready);
  modport slave  (input res_valid, res_ch, res_sig, res_mag, res_err, output res_ready);

endinterface

// File: rtl/sigmag_scan_timer.sv
// Settle down-counter and, with SIGMAG_SCAN_TIMEOUT_EN defined, the WAIT watchdog.
module sigmag_scan_timer #(
  parameter int unsigned SETTLE_CYC = 4
`ifdef SIGMAG_SCAN_TIMEOUT_EN
  , parameter int unsigned CNTR_LENGTH = 16
`endif
) (
  input  logic clk,
  input  logic resetn,
  input  logic settle_load,
  input  logic settle_run,
  output logic settle_done_c
`ifdef SIGMAG_SCAN_TIMEOUT_EN
  , input  logic wd_clr,
  input  logic wd_run,
  output logic wd_expire_c
`endif
);

  localparam int unsigned SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned SETTLE_LOAD = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;

  logic [SW-1:0] settle_cnt_q;

  // Loaded with SETTLE_CYC-1 so the FSM spends exactly SETTLE_CYC cycles in SETTLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      settle_cnt_q <= '0;
    end else if (settle_load) begin
      settle_cnt_q <= SW'(SETTLE_LOAD);
    end else if (settle_run && (settle_cnt_q != '0)) begin
      settle_cnt_q <= settle_cnt_q - SW'(1);
    end
  end

  assign settle_done_c = (settle_cnt_q == '0);

`ifdef SIGMAG_SCAN_TIMEOUT_EN
  localparam int unsigned WDW = (CNTR_LENGTH < 4) ? 6 : CNTR_LENGTH + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((64'd1 << CNTR_LENGTH) + 64'd15);

  logic [WDW-1:0] wd_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt_q <= '0;
    end else if (wd_clr) begin
      wd_cnt_q <= '0;
    end else if (wd_run) begin
      wd_cnt_q <= wd_cnt_q + WDW'(1);
    end
  end

  assign wd_expire_c = wd_run && (wd_cnt_q == WD_LAST);
`endif

endmodule

// File: rtl/sigmag_scan_ctrl.sv
// Scans masked ADC inputs through the sign/magnitude statistic counter and
// presents one result per channel. SIGMAG_SCAN_TIMEOUT_EN adds a WAIT watchdog.
module sigmag_scan_ctrl
  import sigmag_pkg::*;
#(
  parameter int unsigned NCH         = NCH_DEF,
  parameter int unsigned CNTR_LENGTH = CNTR_LENGTH_DEF,
  parameter int unsigned SETTLE_CYC  = 4,
  localparam int unsigned CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [NCH-1:0]         ch_mask,
  output logic [CHW-1:0]         hist_inp,
  output logic                   meas_resetp,
  input  logic                   meas_done,
  input  logic [CNTR_LENGTH-1:0] sig_in,
  input  logic [CNTR_LENGTH-1:0] mag_in,
  output logic                   busy,
  output logic                   scan_done,
  sigmag_scan_ctrl_if.master     res
);

  localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);

  state_e         state_q, state_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [CHW-1:0] ch_q, ch_d, hist_inp_d;
  logic           meas_resetp_d, busy_d, scan_done_d, res_valid_d;
  res_t           res_q, res_d;
  logic           settle_load_c, settle_run_c, settle_done_c;
`ifdef SIGMAG_SCAN_TIMEOUT_EN
  logic           wd_clr_c, wd_run_c, wd_expire_c;
`endif

  sigmag_scan_timer #(
    .SETTLE_CYC   (SETTLE_CYC)
`ifdef SIGMAG_SCAN_TIMEOUT_EN
    , .CNTR_LENGTH(CNTR_LENGTH)
`endif
  ) u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .settle_load  (settle_load_c),
    .settle_run   (settle_run_c),
    .settle_done_c(settle_done_c)
`ifdef SIGMAG_SCAN_TIMEOUT_EN
    , .wd_clr     (wd_clr_c),
    .wd_run       (wd_run_c),
    .wd_expire_c  (wd_expire_c)
`endif
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      ch_q          <= '0;
      hist_inp      <= '0;
      meas_resetp   <= 1'b0;
      busy          <= 1'b0;
      scan_done     <= 1'b0;
      res.res_valid <= 1'b0;
      res_q         <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      ch_q          <= ch_d;
      hist_inp      <= hist_inp_d;
      meas_resetp   <= meas_resetp_d;
      busy          <= busy_d;
      scan_done     <= scan_done_d;
      res.res_valid <= res_valid_d;
      res_q         <= res_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    ch_d          = ch_q;
    hist_inp_d    = hist_inp;
    meas_resetp_d = 1'b0;
    busy_d        = busy;
    scan_done_d   = 1'b0;
    res_valid_d   = res.res_valid;
    res_d         = res_q;
    settle_load_c = 1'b0;
    settle_run_c  = 1'b0;
`ifdef SIGMAG_SCAN_TIMEOUT_EN
    wd_clr_c      = 1'b0;
    wd_run_c      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = ch_mask;
          ch_d    = '0;
          busy_d  = 1'b1;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (mask_q[ch_q]) begin
          hist_inp_d    = ch_q;
          settle_load_c = 1'b1;
          if (SETTLE_CYC == 0) begin
            meas_resetp_d = 1'b1;
            state_d       = CLEAR;
          end else begin
            state_d = SETTLE;
          end
        end else begin
          state_d = NEXT;
        end
      end
      SETTLE: begin
        settle_run_c = 1'b1;
        if (settle_done_c) begin
          meas_resetp_d = 1'b1;
          state_d       = CLEAR;
        end
      end
      CLEAR: state_d = ARM;
      // The counter's done flag lags its clear by a cycle, so it is not looked at here.
      ARM: begin
`ifdef SIGMAG_SCAN_TIMEOUT_EN
        wd_clr_c = 1'b1;
`endif
        state_d = WAIT;
      end
      WAIT: begin
`ifdef SIGMAG_SCAN_TIMEOUT_EN
        wd_run_c = 1'b1;
`endif
        if (meas_done) begin
          res_d.ch    = RES_CH_MAX'(ch_q);
          res_d.sig   = RES_CNT_MAX'(sig_in);
          res_d.mag   = RES_CNT_MAX'(mag_in);
          res_d.err   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = PRESENT;
        end
`ifdef SIGMAG_SCAN_TIMEOUT_EN
        else if (wd_expire_c) begin
          res_d.ch    = RES_CH_MAX'(ch_q);
          res_d.sig   = '0;
          res_d.mag   = '0;
          res_d.err   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = PRESENT;
        end
`endif
      end
      PRESENT: begin
        if (res.res_valid && res.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = NEXT;
        end
      end
      NEXT: begin
        if (ch_q == CH_LAST) begin
          scan_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = FINISH;
        end else begin
          ch_d    = CHW'(ch_q + CHW'(1));
          state_d = SELECT;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign res.res_ch  = res_q.ch[CHW-1:0];
  assign res.res_sig = res_q.sig[CNTR_LENGTH-1:0];
  assign res.res_mag = res_q.mag[CNTR_LENGTH-1:0];
  assign res.res_err = res_q.err;

  // Payload bits above the configured widths are always zero.
  logic unused_res_c;
  assign unused_res_c = ^{res_q.ch >> CHW, res_q.sig >> CNTR_LENGTH, res_q.mag >> CNTR_LENGTH};

endmodule

// File: tb/tb_sigmag_scan_ctrl.sv
// Self-checking bench for sigmag_scan_ctrl with a behavioural statistic counter.
module tb_sigmag_scan_ctrl;

  localparam int unsigned NCH = 4;
`ifdef SIGMAG_SCAN_TIMEOUT_EN
  localparam int unsigned CL       = 4;
  localparam int          LONG_DLY = 20;
`else
  localparam int unsigned CL       = 16;
  localparam int          LONG_DLY = 100;
`endif
  localparam int unsigned SETTLE = 4;
  localparam int unsigned CHW    = 2;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [CL-1:0]  sig;
    logic [CL-1:0]  mag;
    logic           err;
  } exp_t;

  typedef struct {
    logic [NCH-1:0] mask;
    int             delay;
    int             exp_pulses;
  } vec_t;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic [CHW-1:0] hist_inp;
  logic           meas_resetp;
  logic           meas_done = 1'b0;
  logic [CL-1:0]  sig_in, mag_in;
  logic           busy, scan_done;

  sigmag_scan_ctrl_if #(.NCH(NCH), .CNTR_LENGTH(CL)) rif ();

  sigmag_scan_ctrl #(.NCH(NCH), .CNTR_LENGTH(CL), .SETTLE_CYC(SETTLE)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .ch_mask    (ch_mask),
    .hist_inp   (hist_inp),
    .meas_resetp(meas_resetp),
    .meas_done  (meas_done),
    .sig_in     (sig_in),
    .mag_in     (mag_in),
    .busy       (busy),
    .scan_done  (scan_done),
    .res        (rif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CL-1:0] sig_of(input logic [CHW-1:0] c);
    return CL'(32'h1234_5671 + 32'(c) * 3);
  endfunction

  function automatic logic [CL-1:0] mag_of(input logic [CHW-1:0] c);
    return CL'(32'hFEDC_BA98 - 32'(c) * 5);
  endfunction

  // Counter model: 0 = done after done_delay cycles, 1 = done stuck high, 2 = stuck low.
  int mode = 0;
  int done_delay = 100;
  int mcnt = 0;
  assign sig_in = sig_of(hist_inp);
  assign mag_in = mag_of(hist_inp);

  always @(negedge clk) begin
    if (meas_resetp) mcnt = 0;
    else mcnt = mcnt + 1;
    case (mode)
      1:       meas_done = 1'b1;
      2:       meas_done = 1'b0;
      default: meas_done = !meas_resetp && (mcnt >= done_delay);
    endcase
  end

  // Monitor and scoreboard
  exp_t q[$];
  int   cyc = 0, pulses = 0, rises = 0, dones = 0;
  int   last_pulse_cyc = 0, rise_cyc = 0, start_cyc = 0, done_cyc = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (resetn) begin
      if (meas_resetp) begin
        pulses++;
        last_pulse_cyc = cyc;
      end
      if (rif.res_valid && !prev_valid) begin
        rises++;
        rise_cyc = cyc;
      end
      if (scan_done) begin
        dones++;
        done_cyc = cyc;
      end
      if (start && !busy) start_cyc = cyc;
      if (rif.res_valid && rif.res_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 64'(rif.res_ch), 64'hFFFF);
        end else begin
          e = q.pop_front();
          chk("result", 64'({rif.res_ch, rif.res_sig, rif.res_mag, rif.res_err}), 64'(e));
        end
      end
    end
    prev_valid = rif.res_valid;
  end

  task automatic push_exp(input logic [NCH-1:0] m);
    exp_t e;
    for (int c = 0; c < NCH; c++) begin
      if (m[c]) begin
        e.ch  = CHW'(c);
        e.sig = (mode == 2) ? '0 : sig_of(CHW'(c));
        e.mag = (mode == 2) ? '0 : mag_of(CHW'(c));
        e.err = (mode == 2);
        q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(input logic [NCH-1:0] m);
    @(posedge clk); #1;
    ch_mask = m;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    ch_mask = ~m;
  endtask

  task automatic wait_done(input int d0, input int limit);
    for (int i = 0; i < limit && dones == d0; i++) @(posedge clk);
    @(negedge clk);
    chk("scan_done_seen", 64'(dones - d0), 64'd1);
  endtask

  task automatic run_scan(input logic [NCH-1:0] m, input int delay, input int exp_pulses,
                          input int limit);
    int p0, r0, d0;
    done_delay = delay;
    push_exp(m);
    p0 = pulses;
    r0 = rises;
    d0 = dones;
    pulse_start(m);
    chk("busy_after_start", 64'(busy), 64'd1);
    // A start while busy must be ignored.
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(d0, limit);
    chk("meas_resetp_pulses", 64'(pulses - p0), 64'(exp_pulses));
    chk("res_valid_count", 64'(rises - r0), 64'(exp_pulses));
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  vec_t tbl[5];

  initial begin
    int   p0, r0, d0, bad;
    logic [63:0] snap;

    tbl[0] = '{4'b0101, LONG_DLY, 2};
    tbl[1] = '{4'b1111, 3, 4};
    tbl[2] = '{4'b0000, 5, 0};
    tbl[3] = '{4'b1000, 1, 1};
    tbl[4] = '{4'b0110, 17, 2};

    rif.res_ready = 1'b1;
    @(negedge clk);
    chk("reset_outputs", 64'({hist_inp, meas_resetp, busy, scan_done, rif.res_valid,
                               rif.res_ch, rif.res_sig, rif.res_mag, rif.res_err}), 64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 64'({busy, scan_done, meas_resetp, rif.res_valid}), 64'd0);

    for (int i = 0; i < 5; i++) run_scan(tbl[i].mask, tbl[i].delay, tbl[i].exp_pulses, 2000);

    // Empty mask: scan_done within 2*NCH+2 cycles of start.
    run_scan(4'b0000, 5, 0, 50);
    chk("empty_mask_latency_ok", 64'((done_cyc - start_cyc) <= int'(2 * NCH + 2)), 64'd1);

    // Back-pressure: result held stable and no advance while res_ready is low.
    rif.res_ready = 1'b0;
    done_delay = 20;
    push_exp(4'b0011);
    p0 = pulses;
    r0 = rises;
    d0 = dones;
    pulse_start(4'b0011);
    for (int i = 0; i < 300 && rises == r0; i++) @(negedge clk);
    chk("bp_valid_seen", 64'(rises - r0), 64'd1);
    snap = 64'({rif.res_ch, rif.res_sig, rif.res_mag, rif.res_err});
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!rif.res_valid || snap != 64'({rif.res_ch, rif.res_sig, rif.res_mag, rif.res_err}))
        bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    chk("bp_no_advance_pulses", 64'(pulses - p0), 64'd1);
    chk("bp_hist_inp_held", 64'(hist_inp), 64'd0);
    rif.res_ready = 1'b1;
    wait_done(d0, 500);
    chk("bp_total_pulses", 64'(pulses - p0), 64'd2);
    chk("bp_scoreboard_empty", 64'(q.size()), 64'd0);

    // meas_done stuck high: capture only after the ARM guard cycle.
    mode = 1;
    run_scan(4'b0100, 0, 1, 200);
    chk("arm_guard_ok", 64'((rise_cyc - last_pulse_cyc) >= 3), 64'd1);
    mode = 0;

    // Reset during WAIT of ch 1, then a fresh scan starts at ch 0.
    done_delay = 200;
    push_exp(4'b0011);
    p0 = pulses;
    pulse_start(4'b0011);
    for (int i = 0; i < 500 && (pulses - p0) < 2; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    chk("rst_mid_hist_inp", 64'(hist_inp), 64'd1);
    #1 resetn = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", 64'({hist_inp, meas_resetp, busy, scan_done, rif.res_valid,
                                 rif.res_ch, rif.res_sig, rif.res_mag, rif.res_err}), 64'd0);
    q.delete();
    @(posedge clk);
    #1 resetn = 1'b1;
    run_scan(4'b1111, 4, 4, 2000);

`ifdef SIGMAG_SCAN_TIMEOUT_EN
    // Watchdog: 2**4+16 = 32 WAIT cycles, zeros with res_err, scan continues.
    mode = 2;
    run_scan(4'b0011, 0, 2, 600);
    chk("timeout_latency", 64'(rise_cyc - last_pulse_cyc), 64'd34);
    mode = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete, %0d errors so far", errors);
    $fatal(1);
  end

endmodule
